instr_loader: RTL and testbench

//   Upstream boot stage for the core. Accepts 32-bit firmware words over a

---
 rtl/instr_loader.sv | 152 +++++++++++++++
 tb/tb_instr_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: boot-time firmware loader for the core.
//   Accepts 32-bit firmware words on a valid/ready stream and writes each one
//   into byte-addressed instruction memory as four little-endian byte writes,
//   then releases the core from reset once the image is complete.
//
// Parameters
//   ADDR_W     byte address width of the instruction memory
//   MAX_WORDS  image size limit in words (must be <= 2**(ADDR_W-2))
//   BASE_ADDR  byte address of word 0 (must be a multiple of 4)
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   start                1-cycle pulse, begins a new load from IDLE or DONE
//   in_valid/in_ready    stream handshake; in_data/in_last qualified by it
//   mem_we/addr/wdata    byte write port into instruction memory
//   core_rst             holds the core in reset until the image is done
//   busy, done           status: receiving/writing, image complete
//   overflow             sticky: MAX_WORDS reached without in_last
//   word_cnt             words fully written during the current load
//
// Every output is a flop; a word accepted on edge N is written on the four
// cycles that follow, and the loader is ready again (or done) on the fifth.
module instr_loader #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned MAX_WORDS = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_data,
    input  logic                           in_last,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [7:0]                     mem_wdata,
    output logic                           core_rst,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_cnt
);

    localparam int unsigned       CntW     = $clog2(MAX_WORDS + 1);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [CntW-1:0]   CntMax   = CntW'(MAX_WORDS);
    localparam logic [CntW-1:0]   CntOne   = CntW'(1);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       data_q, data_d;
    logic              last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRecv;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StRecv: begin
                if (in_valid && in_ready) begin
                    state_d = StWrite;
                    data_d  = in_data;
                    last_d  = in_last;
                    byte_d  = 2'd0;
                    // First byte goes out on the very next cycle.
                    we_d    = 1'b1;
                    addr_d  = BaseAddr + ADDR_W'({cnt_q, 2'b00});
                    wdata_d = in_data[7:0];
                end
            end
            StWrite: begin
                if (byte_q == 2'd3) begin
                    cnt_d = cnt_q + CntOne;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (cnt_q + CntOne == CntMax) begin
                        state_d = StDone;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = StRecv;
                    end
                end else begin
                    byte_d  = byte_q + 2'd1;
                    we_d    = 1'b1;
                    addr_d  = mem_addr + ADDR_W'(1);
                    wdata_d = data_q[{byte_q + 2'd1, 3'b000} +: 8];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            byte_q    <= 2'd0;
            data_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            core_rst  <= 1'b1;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            // Status flops are decoded from the next state so they line up
            // with state_q rather than lagging it by a cycle.
            in_ready  <= (state_d == StRecv);
            busy      <= (state_d == StRecv) || (state_d == StWrite);
            done      <= (state_d == StDone);
            core_rst  <= (state_d != StDone);
        end
    end

    assign word_cnt = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int ADDR_W    = 7;
    localparam int MAX_WORDS = 32;
    localparam int CW        = $clog2(MAX_WORDS + 1);
    localparam int MEM_SZ    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_data = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CW-1:0]     word_cnt;

    instr_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .BASE_ADDR(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory behind the loader, plus a handshake/ready monitor.
    logic [7:0]  mem     [MEM_SZ];
    logic [7:0]  exp_mem [MEM_SZ];
    int          cyc = 0;
    int          nwr = 0;
    int          hs_cyc[$];
    logic [31:0] hs_data[$];
    logic        log_en = 1'b0;
    logic        rdy_log[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            nwr <= nwr + 1;
        end
        if (in_valid && in_ready) begin
            hs_cyc.push_back(cyc);
            hs_data.push_back(in_data);
        end
        if (log_en) rdy_log.push_back(in_ready);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_core_rst"},  32'(core_rst),  32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_overflow"},  32'(overflow),  32'd0);
        chk({tag, "_word_cnt"},  32'(word_cnt),  32'd0);
    endtask

    // Expected memory image: word i lands little-endian at byte 4*i.
    task automatic model_word(input int idx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_mem[4 * idx + k] = w[8 * k +: 8];
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < MEM_SZ; a++) chk({tag, "_mem"}, 32'(mem[a]), 32'(exp_mem[a]));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one word, hold it until accepted; returns on the negedge after
    // the accepting edge (first write cycle).
    task automatic send(input logic [31:0] d, input logic l, input int gap);
        int  n;
        logic got;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            got = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", 32'(done), 32'd1);
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    vec_t        tbl[3];
    logic [31:0] w;
    int          n0;
    int          nw;

    initial begin
        tbl[0] = '{32'h00500093, 1'b0, 8'h93, 8'h00, 8'h50, 8'h00};
        tbl[1] = '{32'h00A00113, 1'b0, 8'h13, 8'h01, 8'hA0, 8'h00};
        tbl[2] = '{32'h002081B3, 1'b1, 8'hB3, 8'h81, 8'h20, 8'h00};
        for (int a = 0; a < MEM_SZ; a++) begin
            mem[a]     = 8'h00;
            exp_mem[a] = 8'h00;
        end

        // Reset values, then idle after release.
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle");

        // in_valid while IDLE is ignored.
        n0 = nwr;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_no_hs", 32'(hs_cyc.size()), 32'd0);
        chk("idle_no_write", 32'(nwr - n0), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Three-word program from the table.
        hs_cyc.delete();
        pulse_start();
        chk("t1_core_rst", 32'(core_rst), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) send(tbl[i].data, tbl[i].last, 0);
        wait_done(40);
        chk("t1_done_latency", 32'(cyc - hs_cyc[0]), 32'd15);
        chk("t1_core_rst_done", 32'(core_rst), 32'd0);
        chk("t1_word_cnt", 32'(word_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_b0", 32'(mem[4 * i]),     32'(tbl[i].b0));
            chk("t1_b1", 32'(mem[4 * i + 1]), 32'(tbl[i].b1));
            chk("t1_b2", 32'(mem[4 * i + 2]), 32'(tbl[i].b2));
            chk("t1_b3", 32'(mem[4 * i + 3]), 32'(tbl[i].b3));
            model_word(i, tbl[i].data);
        end

        // Continuous in_valid: ready pattern 1,0,0,0,0 per word.
        hs_cyc.delete();
        hs_data.delete();
        rdy_log.delete();
        nw = 6;
        pulse_start();
        log_en = 1'b1;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            model_word(i, w);
            send(w, i == nw - 1, 0);
            chk("t2_hs_data", hs_data[i], w);
        end
        wait_done(20);
        log_en = 1'b0;
        chk("t2_hs_count", 32'(hs_cyc.size()), 32'(nw));
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t2_hs_spacing", 32'(hs_cyc[i] - hs_cyc[i - 1]), 32'd5);
        chk("t2_log_len", 32'(rdy_log.size() >= 5 * nw), 32'd1);
        for (int i = 0; i < 5 * nw && i < rdy_log.size(); i++)
            chk("t2_ready_pattern", 32'(rdy_log[i]), 32'(i % 5 == 0));
        chk("t2_word_cnt", 32'(word_cnt), 32'(nw));
        check_mem("t2");

        // Full image without in_last: overflow.
        hs_cyc.delete();
        n0 = nwr;
        pulse_start();
        for (int i = 0; i < MAX_WORDS; i++) begin
            w = $urandom;
            model_word(i, w);
            send(w, 1'b0, 0);
        end
        wait_done(20);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_word_cnt", 32'(word_cnt), 32'(MAX_WORDS));
        chk("t3_writes", 32'(nwr - n0), 32'(4 * MAX_WORDS));
        check_mem("t3");
        in_valid = 1'b1;
        in_data  = 32'hCAFEF00D;
        repeat (10) @(negedge clk);
        chk("t3_no_33rd", 32'(hs_cyc.size()), 32'(MAX_WORDS));
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Reload from DONE.
        pulse_start();
        chk("t5_core_rst", 32'(core_rst), 32'd1);
        chk("t5_done_low", 32'(done), 32'd0);
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        chk("t5_cnt_clr", 32'(word_cnt), 32'd0);
        send(32'hDEADBEEF, 1'b1, 0);
        chk("t5_core_rst_load", 32'(core_rst), 32'd1);
        wait_done(20);
        model_word(0, 32'hDEADBEEF);
        chk("t5_m0", 32'(mem[0]), 32'hEF);
        chk("t5_m1", 32'(mem[1]), 32'hBE);
        chk("t5_m2", 32'(mem[2]), 32'hAD);
        chk("t5_m3", 32'(mem[3]), 32'hDE);
        chk("t5_word_cnt", 32'(word_cnt), 32'd1);

        // start while WRITE and while RECV is ignored.
        pulse_start();
        w = $urandom;
        model_word(0, w);
        send(w, 1'b0, 0);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("t6_recv_ready", 32'(in_ready), 32'd1);
        pulse_start();
        chk("t6_still_recv", 32'(in_ready), 32'd1);
        chk("t6_cnt_kept", 32'(word_cnt), 32'd1);
        w = $urandom;
        model_word(1, w);
        send(w, 1'b1, 0);
        wait_done(20);
        chk("t6_word_cnt", 32'(word_cnt), 32'd2);
        check_mem("t6");

        // Reset during byte 2 of word 5; bytes 0,1 already landed.
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            if (i < 5) model_word(i, w);
            send(w, 1'b0, 0);
        end
        exp_mem[20] = w[7:0];
        exp_mem[21] = w[15:8];
        repeat (2) @(negedge clk);
        chk("t4_byte2_we", 32'(mem_we), 32'd1);
        chk("t4_byte2_addr", 32'(mem_addr), 32'd22);
        rst = 1'b1;
        #1;
        check_reset_vals("t4_async");
        @(negedge clk);
        check_reset_vals("t4_held");
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            model_word(i, w);
            send(w, i == 1, 0);
        end
        wait_done(20);
        chk("t4_word_cnt", 32'(word_cnt), 32'd2);
        check_mem("t4");

        // Random loads with random bubbles.
        for (int r = 0; r < 4; r++) begin
            nw = $urandom_range(1, MAX_WORDS - 1);
            hs_cyc.delete();
            pulse_start();
            for (int i = 0; i < nw; i++) begin
                w = $urandom;
                model_word(i, w);
                send(w, i == nw - 1, $urandom_range(0, 3));
            end
            wait_done(20);
            chk("rnd_word_cnt", 32'(word_cnt), 32'(nw));
            chk("rnd_hs_count", 32'(hs_cyc.size()), 32'(nw));
            chk("rnd_overflow", 32'(overflow), 32'd0);
            chk("rnd_core_rst", 32'(core_rst), 32'd0);
            check_mem("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
